// File: rtl/latch_sampler.sv
// Captures the value held by a level-enabled latch each time its enable closes,
// queues it in a small FIFO and hands it downstream over valid/ready.
module latch_sampler #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overrun,
    output logic [CNT_W-1:0]           overrun_cnt,
    input  logic                       ovr_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic                   en_q;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic                   cap;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   full;

    // Handshake: a word transfers on any cycle where out_valid and out_ready
    // are both high; while out_valid is high and out_ready low, out_valid and
    // out_data hold. out_ready has no effect while the FIFO is empty.
    assign full      = (level == FULL_LVL);
    assign cap       = en_q & ~en;
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q   <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            en_q <= en;
            if (push) begin
                mem[wr_ptr] <= d;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (ovr_clr) begin
            overrun     <= drop;
            overrun_cnt <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (!(&overrun_cnt)) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_latch_sampler.sv
// Directed bench for latch_sampler: capture, fill/drop, full push+pop,
// counter saturation/clear and mid-operation reset.
module tb_latch_sampler;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [WIDTH-1:0]       d;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [$clog2(DEPTH):0] level;
    logic                   overrun;
    logic [CNT_W-1:0]       overrun_cnt;
    logic                   ovr_clr;

    int n_checks = 0;
    int n_errors = 0;

    latch_sampler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .d           (d),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .ovr_clr     (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Open then close the latch enable with value v present on d at the close.
    task automatic close_latch(input logic [WIDTH-1:0] v);
        en = 1'b1;
        tick();
        en = 1'b0;
        d  = v;
        tick();
    endtask

    task automatic check_fifo(input string tag, input int lvl, input logic vld, input logic [WIDTH-1:0] data);
        check({tag, "_level"}, 32'(level), 32'(lvl));
        check({tag, "_valid"}, 32'(out_valid), 32'(vld));
        if (vld) check({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; d = 8'hFF; out_ready = 1'b0; ovr_clr = 1'b0;

        // Reset held three cycles with the latch transparent.
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_cnt", 32'(overrun_cnt), 0);
        rst = 1'b1;
        tick();
        check("rst_release_level", 32'(level), 0);

        // Single capture, held until accepted.
        en = 1'b0; d = 8'hA5;
        tick();
        check_fifo("single", 1, 1'b1, 8'hA5);
        tick();
        check_fifo("single_hold", 1, 1'b1, 8'hA5);
        out_ready = 1'b1;
        tick();
        check_fifo("single_pop", 0, 1'b0, 8'h00);

        // out_ready is ignored while empty.
        tick();
        check("empty_ready_level", 32'(level), 0);
        out_ready = 1'b0;

        // Push+pop at level 1: new word shows next cycle.
        close_latch(8'h55);
        check_fifo("lvl1_pre", 1, 1'b1, 8'h55);
        en = 1'b1;
        tick();
        en = 1'b0; d = 8'h66; out_ready = 1'b1;
        tick();
        check_fifo("lvl1_pushpop", 1, 1'b1, 8'h66);
        tick();
        check_fifo("lvl1_drain", 0, 1'b0, 8'h00);
        out_ready = 1'b0;

        // Fill and overrun: 33 dropped.
        close_latch(8'h11);
        close_latch(8'h22);
        close_latch(8'h33);
        check_fifo("fill", 2, 1'b1, 8'h11);
        check("fill_overrun", 32'(overrun), 1);
        check("fill_cnt", 32'(overrun_cnt), 1);

        // Push+pop at full: 11 leaves, 44 enters, no new drop.
        en = 1'b1;
        tick();
        en = 1'b0; d = 8'h44; out_ready = 1'b1;
        tick();
        check_fifo("full_pushpop", 2, 1'b1, 8'h22);
        check("full_pushpop_overrun", 32'(overrun), 1);
        check("full_pushpop_cnt", 32'(overrun_cnt), 1);
        tick();
        check_fifo("drain_44", 1, 1'b1, 8'h44);
        tick();
        check_fifo("drain_empty", 0, 1'b0, 8'h00);
        out_ready = 1'b0;

        // Clear, then saturate the 2-bit counter.
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("clr_overrun", 32'(overrun), 0);
        check("clr_cnt", 32'(overrun_cnt), 0);
        close_latch(8'h01);
        close_latch(8'h02);
        for (int i = 0; i < 5; i++) close_latch(8'hE0 + 8'(i));
        check("sat_cnt", 32'(overrun_cnt), 3);
        check("sat_overrun", 32'(overrun), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("sat_clr_cnt", 32'(overrun_cnt), 0);
        check("sat_clr_overrun", 32'(overrun), 0);
        check_fifo("clr_keeps_fifo", 2, 1'b1, 8'h01);

        // Clear coinciding with a drop.
        en = 1'b1;
        tick();
        en = 1'b0; d = 8'hEE; ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("clr_drop_overrun", 32'(overrun), 1);
        check("clr_drop_cnt", 32'(overrun_cnt), 1);
        check_fifo("clr_drop_fifo", 2, 1'b1, 8'h01);

        // Mid-operation reset with the latch open, released with it closed.
        en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_fifo("midrst", 0, 1'b0, 8'h00);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_overrun", 32'(overrun), 0);
        check("midrst_cnt", 32'(overrun_cnt), 0);
        rst = 1'b1; en = 1'b0; d = 8'h77;
        tick();
        check("midrst_no_cap", 32'(level), 0);
        tick();
        check("midrst_no_cap2", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
